// File: rtl/store_buffer.sv
// store_buffer: in-order store buffer between the M stage and data memory.
//
// Stores are sized and lane-positioned on entry, queued in a circular FIFO of
// DEPTH entries and drained to memory strictly in push order. Loads probe the
// buffer by word address. With STORE_BUF_FWD_EN defined, matching bytes are
// forwarded (youngest entry wins per lane). Without it, any match stalls the load.
//
// Optional feature macro: STORE_BUF_FWD_EN
//
// Ports:
//   clk, reset                    clock; synchronous active-high reset
//   in_valid/in_ready             store request handshake
//   in_op                         0 word, 1 byte, 2 half, 3 illegal
//   in_addr, in_data, in_pc       byte address, raw store data, store PC
//   mem_we/mem_ready              head entry valid / accepted by memory
//   mem_addr, mem_wdata, mem_be   word-aligned address, lane data, byte enables
//   mem_pc                        PC of the head entry
//   ld_valid, ld_addr             load probe
//   ld_stall, ld_fwd_be/data      load must wait / forwarded bytes
//   err                           one-cycle pulse after an illegal request is consumed
//   count                         occupancy
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  input  logic [31:0]              in_pc,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [31:0]              mem_pc,
  output logic [3:0]               mem_be,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_addr,
  output logic                     ld_stall,
  output logic [3:0]               ld_fwd_be,
  output logic [31:0]              ld_fwd_data,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry payload; intentionally not reset, validity is tracked by count_q.
  logic [29:0] addr_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [3:0]  be_q   [DEPTH];
  logic [31:0] pc_q   [DEPTH];

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            err_q, err_d;

  logic        req_legal;
  logic [3:0]  req_be;
  logic [31:0] req_data;
  logic        push, pop;

  // Request decode and lane placement.
  always_comb begin
    req_legal = 1'b0;
    req_be    = 4'b0000;
    req_data  = 32'h0;
    case (in_op)
      2'd0: begin
        req_legal = (in_addr[1:0] == 2'b00);
        req_be    = 4'b1111;
        req_data  = in_data;
      end
      2'd1: begin
        req_legal = 1'b1;
        req_be    = 4'b0001 << in_addr[1:0];
        req_data  = {24'h0, in_data[7:0]} << {in_addr[1:0], 3'b000};
      end
      2'd2: begin
        req_legal = ~in_addr[0];
        req_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        req_data  = in_addr[1] ? {in_data[15:0], 16'h0} : {16'h0, in_data[15:0]};
      end
      default: begin
        req_legal = 1'b0;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, never on mem_ready.
  assign in_ready = (count_q < CntW'(DEPTH));
  assign mem_we   = (count_q != '0);
  assign push     = in_valid & in_ready & req_legal;
  assign pop      = mem_we & mem_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Illegal requests are still consumed through the handshake.
    err_d   = in_valid & in_ready & ~req_legal;
    if (push) tail_d = tail_q + 1'b1;
    if (pop)  head_d = head_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Payload write; a push coincident with reset is harmless since count_q clears.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= in_addr[31:2];
      data_q[tail_q] <= req_data;
      be_q[tail_q]   <= req_be;
      pc_q[tail_q]   <= in_pc;
    end
  end

  assign mem_addr  = {addr_q[head_q], 2'b00};
  assign mem_wdata = data_q[head_q];
  assign mem_be    = be_q[head_q];
  assign mem_pc    = pc_q[head_q];
  assign err       = err_q;
  assign count     = count_q;

  // Load probe. Entries are walked oldest to youngest so younger matches
  // overwrite older ones; the head counts as present even while it pops.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx         = head_q;
    ld_stall    = 1'b0;
    ld_fwd_be   = 4'b0000;
    ld_fwd_data = 32'h0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (ld_valid && (CntW'(i) < count_q) && (addr_q[idx] == ld_addr[31:2])) begin
`ifdef STORE_BUF_FWD_EN
        for (int unsigned b = 0; b < 4; b++) begin
          if (be_q[idx][b]) begin
            ld_fwd_be[b]          = 1'b1;
            ld_fwd_data[8*b +: 8] = data_q[idx][8*b +: 8];
          end
        end
`else
        ld_stall = 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus randomized traffic, all
// checked cycle by cycle against a queue-based reference model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_addr, in_data, in_pc;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_pc;
  logic [3:0]  mem_be;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_stall;
  logic [3:0]  ld_fwd_be;
  logic [31:0] ld_fwd_data;
  logic        err;
  logic [2:0]  count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_pc      (in_pc),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_pc     (mem_pc),
    .mem_be     (mem_be),
    .ld_valid   (ld_valid),
    .ld_addr    (ld_addr),
    .ld_stall   (ld_stall),
    .ld_fwd_be  (ld_fwd_be),
    .ld_fwd_data(ld_fwd_data),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  logic err_exp = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] drain_exp [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference packing from the store-width rules.
  task automatic ref_pack(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                          output logic legal, output logic [3:0] be, output logic [31:0] data);
    int lane;
    lane  = int'(a[1:0]);
    legal = 1'b0;
    be    = 4'h0;
    data  = 32'h0;
    if (op == 2'd0) begin
      legal = (lane == 0);
      be    = 4'hF;
      data  = d;
    end else if (op == 2'd1) begin
      legal = 1'b1;
      be    = 4'(1 << lane);
      data  = (d & 32'hFF) << (8 * lane);
    end else if (op == 2'd2) begin
      legal = (a[0] == 1'b0);
      be    = (lane >= 2) ? 4'hC : 4'h3;
      data  = (d & 32'hFFFF) << ((lane >= 2) ? 16 : 0);
    end
  endtask

  task automatic ref_load(output logic st, output logic [3:0] fbe, output logic [31:0] fd);
    st  = 1'b0;
    fbe = 4'h0;
    fd  = 32'h0;
    for (int i = 0; i < q.size(); i++) begin
      if (ld_valid && q[i].wa == ld_addr[31:2]) begin
`ifdef STORE_BUF_FWD_EN
        for (int b = 0; b < 4; b++) begin
          if (q[i].be[b]) begin
            fbe[b]       = 1'b1;
            fd[8*b +: 8] = q[i].data[8*b +: 8];
          end
        end
`else
        st = 1'b1;
`endif
      end
    end
  endtask

  task automatic check_all();
    logic        st;
    logic [3:0]  fbe;
    logic [31:0] fd;
    check_eq("in_ready", in_ready, q.size() < DEPTH);
    check_eq("count", count, q.size());
    check_eq("mem_we", mem_we, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("mem_addr", mem_addr, {q[0].wa, 2'b00});
      check_eq("mem_wdata", mem_wdata, q[0].data);
      check_eq("mem_be", mem_be, q[0].be);
      check_eq("mem_pc", mem_pc, q[0].pc);
    end
    ref_load(st, fbe, fd);
    check_eq("ld_stall", ld_stall, st);
    check_eq("ld_fwd_be", ld_fwd_be, fbe);
    check_eq("ld_fwd_data", ld_fwd_data, fd);
    check_eq("err", err, err_exp);
  endtask

  // Drive inputs mid-cycle, let them settle, then compare against the model.
  task automatic drv(input logic rst, input logic iv, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] d, input logic mr,
                     input logic lv, input logic [31:0] la);
    reset     = rst;
    in_valid  = iv;
    in_op     = op;
    in_addr   = a;
    in_data   = d;
    in_pc     = $urandom;
    mem_ready = mr;
    ld_valid  = lv;
    ld_addr   = la;
    #1;
    if (!rst) check_all();
  endtask

  // Advance one clock and apply the same transaction to the model.
  task automatic tick();
    logic        legal;
    logic [3:0]  be;
    logic [31:0] data;
    logic        acc;
    ent_t        e;
    @(posedge clk);
    ref_pack(in_op, in_addr, in_data, legal, be, data);
    acc = in_valid && (q.size() < DEPTH);
    if (reset) begin
      q.delete();
      err_exp = 1'b0;
    end else begin
      err_exp = acc && !legal;
      if (q.size() != 0 && mem_ready) void'(q.pop_front());
      if (acc && legal) begin
        e.wa   = in_addr[31:2];
        e.data = data;
        e.be   = be;
        e.pc   = in_pc;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drv(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    drv(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();

    // Reset state.
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_ld_stall", ld_stall, 0);

    // Byte store lands in lane 3 and drains immediately.
    drv(1'b0, 1'b1, 2'd1, 32'h0000_0013, 32'h0000_00AB, 1'b1, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("byte_mem_we", mem_we, 1);
    check_eq("byte_mem_addr", mem_addr, 32'h10);
    check_eq("byte_mem_be", mem_be, 4'b1000);
    check_eq("byte_mem_wdata", mem_wdata, 32'hAB00_0000);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("byte_count_after", count, 0);

    // Fill with memory stalled, then drain in order and accept the fifth store.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 1'b1, 2'd0, 32'(4 * k), $urandom, 1'b0, 1'b0, 32'h0);
      tick();
    end
    drv(1'b0, 1'b1, 2'd0, 32'h10, 32'h5555_0005, 1'b0, 1'b0, 32'h0);
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_count", count, 4);
    tick();
    for (int i = 0; i < 5; i++) begin
      drv(1'b0, i < 2, 2'd0, 32'h10, 32'h5555_0005, 1'b1, 1'b0, 32'h0);
      check_eq("drain_addr", mem_addr, drain_exp[i]);
      tick();
    end
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_eq("drain_count", count, 0);

    // Misaligned half store is consumed and flagged.
    drv(1'b0, 1'b1, 2'd2, 32'h0000_0005, 32'h1234, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_eq("illegal_err", err, 1);
    check_eq("illegal_count", count, 0);
    tick();

    // Word then overlapping byte, probed by a load to the same word.
    drv(1'b0, 1'b1, 2'd0, 32'h20, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b1, 2'd1, 32'h21, 32'h0000_00EE, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h20);
`ifdef STORE_BUF_FWD_EN
    check_eq("fwd_be", ld_fwd_be, 4'b1111);
    check_eq("fwd_data", ld_fwd_data, 32'h1122_EE44);
    check_eq("fwd_stall", ld_stall, 0);
`else
    check_eq("nofwd_stall", ld_stall, 1);
    check_eq("nofwd_be", ld_fwd_be, 0);
`endif
    tick();

    // Steady push+pop keeps occupancy while pointers wrap; then reset mid-drain.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 1'b1, 2'd0, 32'(32'h40 + 4 * k), $urandom, 1'b0, 1'b0, 32'h0);
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      drv(1'b0, 1'b1, 2'd0, 32'(32'h80 + 4 * k), $urandom, 1'b1, 1'b0, 32'h0);
      check_eq("wrap_count", count, 3);
      tick();
    end
    drv(1'b0, 1'b1, 2'd1, 32'h99, $urandom, 1'b0, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b1, 2'd0, 32'hA0, $urandom, 1'b1, 1'b1, 32'h98);
    check_eq("wrap_full", count, 4);
    tick();
    drv(1'b1, 1'b1, 2'd0, 32'hA4, $urandom, 1'b1, 1'b0, 32'h0);
    tick();
    drv(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h98);
    check_eq("midrst_mem_we", mem_we, 0);
    check_eq("midrst_count", count, 0);
    tick();

    // Randomized traffic over a small address window to provoke load matches.
    for (int n = 0; n < 2000; n++) begin
      logic [1:0] op;
      op = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      drv(($urandom_range(0, 99) == 0), $urandom_range(0, 2) != 0, op,
          32'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
